mem_port_arbiter: RTL

Shares one single-ported 64-bit memory between the CPU's instruction-fetch port and its data (LDUR/STUR) port. Each requester issues a request and holds it until granted. The arbiter then runs one memory transaction at a time and returns read data with a one-cycle valid pulse. It sits between the CPU core and the unified memory model, and it replaces separate instruction and data memories when the core is built against a single RAM.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported 64-bit memory between instruction fetch and data ports.
// Latency : grant 1 cycle after request; valid 1 cycle after mem_ack (min 2 cycles request->valid).
// Backpressure: requesters hold req until gnt; requests seen while busy are ignored, not queued.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr -> if_gnt       fetch request and one-cycle accept pulse
//   if_rdata/if_valid              selected 32-bit instruction word and completion pulse
//   d_req/d_we/d_addr/d_wdata      data request (load or store)
//   d_gnt, d_rdata/d_valid         data accept pulse, load data and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack   memory side
//   err                            pulses with valid when the transaction timed out
//   busy                           FSM not idle
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic [63:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        busy
);

    // One extra bit so the counter can never wrap before reaching TIMEOUT-1.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          last_d;     // 1: data port was granted most recently
    logic          addr_hi;    // latched if_addr[2], selects upper instruction word
    logic          pick_d;
    logic          pick_i;
    logic          expire;

    // Round-robin on contention: the port not granted last wins.
    always_comb begin
        pick_d = d_req & (~if_req | ~last_d);
        pick_i = if_req & (~d_req | last_d);
        expire = (cnt == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = D_BUSY;
                end else if (pick_i) begin
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (mem_ack || expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; they drop with the async reset immediately.
    always_comb begin
        busy    = (state != IDLE);
        mem_req = (state != IDLE);
    end

    // Latched request, counter and registered response pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            last_d    <= 1'b0;
            addr_hi   <= 1'b0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        d_gnt     <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_wdata <= d_wdata;
                        cnt       <= '0;
                        last_d    <= 1'b1;
                    end else if (pick_i) begin
                        if_gnt    <= 1'b1;
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        addr_hi   <= if_addr[2];
                        cnt       <= '0;
                        last_d    <= 1'b0;
                    end
                end
                I_BUSY: begin
                    if (mem_ack) begin
                        if_valid <= 1'b1;
                        if_rdata <= addr_hi ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else if (expire) begin
                        if_valid <= 1'b1;
                        err      <= 1'b1;
                        if_rdata <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        d_valid <= 1'b1;
                        d_rdata <= mem_rdata;
                        mem_we  <= 1'b0;
                    end else if (expire) begin
                        d_valid <= 1'b1;
                        err     <= 1'b1;
                        d_rdata <= '0;
                        mem_we  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
